// File: rtl/shift_divider.sv
// Sequential signed radix-2 restoring divider: one quotient bit per clock,
// start/done handshake, quotient truncated toward zero, remainder takes the dividend's sign.
module shift_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_bz;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_b_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_sh;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Magnitudes are unsigned, so -2^(W-1) maps cleanly onto 2^(W-1).
    assign w_abs_a  = A[WIDTH-1] ? -A : A;
    assign w_abs_b  = B[WIDTH-1] ? -B : B;
    assign w_b_zero = (B == '0);

    // One restoring step; the extra bit of w_trial is the borrow/sign.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_dvsr};
    assign w_quo_sh = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_rem_nx = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

    assign w_q_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_r_fix  = r_sign_r ? -r_rem : r_rem;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_bz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        r_dvsr      <= w_abs_b;
                        r_cnt       <= CW'(WIDTH);
                        r_sign_r    <= A[WIDTH-1];
                        if (w_b_zero) begin
                            // FIX then yields Q = -1 and R = A through the normal sign path.
                            r_quo    <= '1;
                            r_rem    <= w_abs_a;
                            r_sign_q <= 1'b0;
                            r_bz     <= 1'b1;
                            r_state  <= S_FIX;
                        end else begin
                            r_quo    <= w_abs_a;
                            r_rem    <= '0;
                            r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            r_bz     <= 1'b0;
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_quo <= w_quo_sh;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    Q           <= w_q_fix;
                    R           <= w_r_fix;
                    div_by_zero <= r_bz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_divider.sv
// Scoreboard bench for shift_divider: directed sign/corner/handshake cases plus a random identity run.
module tb_shift_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int op_id  = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          dc;
        int          id;
    } exp_t;

    exp_t sb[$];

    shift_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (a_in),
        .B          (b_in),
        .busy       (busy),
        .done       (done),
        .Q          (q),
        .R          (r),
        .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (op %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: every done pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("Q", e.id, q, e.q);
                check("R", e.id, r, e.r);
                check("div_by_zero", e.id, {31'd0, dbz}, {31'd0, e.dz});
                check("done_latency", e.id, 32'(cyc), 32'(e.dc));
            end
        end
    end

    task automatic push(input logic [31:0] eq, input logic [31:0] er, input logic edz, input int dc);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
        e.dc = dc;
        e.id = op_id;
        op_id++;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int acc;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
        push(eq, er, edz, acc + (edz ? 1 : 33));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int acc;
        int nd;
        int ia;
        int ib;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", -1, {31'd0, busy}, 32'd0);
        check("rst_done", -1, {31'd0, done}, 32'd0);
        check("rst_Q", -1, q, 32'd0);
        check("rst_R", -1, r, 32'd0);
        check("rst_dbz", -1, {31'd0, dbz}, 32'd0);
        rst_n = 1'b1;

        issue(25, -5, 32'hFFFF_FFFB, 0, 1'b0);
        wait_done();

        issue(-7, 2, -3, -1, 1'b0); wait_done();
        issue(7, -2, -3, 1, 1'b0);  wait_done();
        issue(-7, -2, 3, -1, 1'b0); wait_done();
        issue(7, 2, 3, 1, 1'b0);    wait_done();

        issue(-5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1); wait_done();
        issue(48, 6, 8, 0, 1'b0); wait_done();

        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0); wait_done();
        issue(32'h8000_0000, 7, -306783378, -2, 1'b0); wait_done();

        // Start while busy is ignored; a held start is taken right after done.
        @(negedge clk);
        a_in  = 100;
        b_in  = 3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
        push(33, 1, 1'b0, acc + 33);
        wait_cyc(acc + 9);
        a_in  = 9;
        b_in  = 9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ignored_start_busy", -1, {31'd0, busy}, 32'd1);
        wait_cyc(acc + 20);
        a_in  = 50;
        b_in  = 7;
        start = 1'b1;
        push(7, 1, 1'b0, acc + 67);
        wait_cyc(acc + 33);
        check("done_cycle_busy", -1, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_accept_busy", -1, {31'd0, busy}, 32'd1);
        wait_done();

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            if (i % 3 == 0) rb = $urandom;
            else if (i % 3 == 1) rb = 32'($urandom_range(1, 1000));
            else rb = -32'($urandom_range(1, 70000));
            if (i % 5 == 0) ra = 32'($signed(ra) >>> 16);
            if (rb == 0) rb = 1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 1;
            ia = $signed(ra);
            ib = $signed(rb);
            issue(ra, rb, 32'(ia / ib), 32'(ia % ib), 1'b0);
            wait_done();
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a_in  = -72;
        b_in  = 6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
        wait_cyc(acc + 15);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", -1, {31'd0, busy}, 32'd0);
        check("async_rst_Q", -1, q, 32'd0);
        check("async_rst_R", -1, r, 32'd0);
        check("async_rst_dbz", -1, {31'd0, dbz}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_rst", -1, 32'(nd), 32'd0);

        issue(-72, 6, -12, 0, 1'b0);
        wait_done();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", -1, 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
